// File: rtl/register_bank_pkg.sv
// Shared constants and types for the register bank and its dump sequencer.
package register_bank_pkg;

  localparam int SIZE_DEF         = 32;
  localparam int SIZE_REG_DIR_DEF = $clog2(SIZE_DEF);
  localparam int NUM_REGS_DEF     = 2 ** SIZE_REG_DIR_DEF;

  // Dump sequencer states: waiting, streaming words, one-cycle completion pulse.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/regbank_dump_seq.sv
// Dump sequencer: walks every register index in order and presents one word
// at a time under a valid/ready handshake. The word for the next index is
// fetched through a read port that the parent drives with bypass applied.
module regbank_dump_seq
  import register_bank_pkg::*;
#(
  parameter int SIZE         = SIZE_DEF,
  parameter int SIZE_REG_DIR = $clog2(SIZE)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_dump_start,
  input  logic                    i_dump_ready,
  output logic [SIZE_REG_DIR-1:0] o_fetch_addr,
  input  logic [SIZE-1:0]         i_fetch_data,
  output logic                    o_dump_valid,
  output logic [SIZE_REG_DIR-1:0] o_dump_idx,
  output logic [SIZE-1:0]         o_dump_data,
  output logic                    o_dump_done
);

  localparam logic [SIZE_REG_DIR-1:0] IDX_ONE = {{(SIZE_REG_DIR-1){1'b0}}, 1'b1};
  localparam logic [SIZE_REG_DIR-1:0] IDX_LAST = '1;

  dump_state_e             state_q, state_d;
  logic [SIZE_REG_DIR-1:0] idx_q, idx_d;
  logic [SIZE-1:0]         data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;

  // The parent looks up the word that would follow the current one.
  assign o_fetch_addr = idx_q + IDX_ONE;

  assign o_dump_valid = valid_q;
  assign o_dump_idx   = idx_q;
  assign o_dump_data  = data_q;
  assign o_dump_done  = done_q;

  // Next-state and next-output logic; a held word stays untouched until accepted.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (i_dump_start) begin
          state_d = ST_DUMP;
          idx_d   = '0;
          data_d  = '0;
          valid_d = 1'b1;
        end
      end
      ST_DUMP: begin
        if (i_dump_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = o_fetch_addr;
            data_d = i_fetch_data;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs; reset aborts any dump silently.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/register_bank.sv
// MIPS-style register file: two combinational read ports with write-back
// bypass, register 0 hard-wired to zero, plus a streaming dump of all registers.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int SIZE         = SIZE_DEF,
  parameter int SIZE_REG_DIR = $clog2(SIZE)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_reg_write,
  input  logic [SIZE_REG_DIR-1:0] i_wr_addr,
  input  logic [SIZE-1:0]         i_wr_data,
  input  logic [SIZE_REG_DIR-1:0] i_rd_addr_a,
  input  logic [SIZE_REG_DIR-1:0] i_rd_addr_b,
  output logic [SIZE-1:0]         o_rd_data_a,
  output logic [SIZE-1:0]         o_rd_data_b,
  input  logic                    i_dump_start,
  input  logic                    i_dump_ready,
  output logic                    o_dump_valid,
  output logic [SIZE_REG_DIR-1:0] o_dump_idx,
  output logic [SIZE-1:0]         o_dump_data,
  output logic                    o_dump_done
);

  localparam int NUM_REGS = 2 ** SIZE_REG_DIR;

  logic [SIZE-1:0]         regs_q [NUM_REGS];
  logic [SIZE-1:0]         regs_d [NUM_REGS];
  logic [SIZE_REG_DIR-1:0] fetch_addr;
  logic [SIZE-1:0]         fetch_data;

  // Post-write view of the file; reading it gives same-cycle bypass for free
  // and keeps register 0 at zero regardless of what is written to it.
  always_comb begin
    regs_d = regs_q;
    if (i_reg_write && (i_wr_addr != '0)) begin
      regs_d[i_wr_addr] = i_wr_data;
    end
    regs_d[0] = '0;
  end

  // Register storage, cleared asynchronously by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign o_rd_data_a = regs_d[i_rd_addr_a];
  assign o_rd_data_b = regs_d[i_rd_addr_b];
  assign fetch_data  = regs_d[fetch_addr];

  regbank_dump_seq #(
    .SIZE         (SIZE),
    .SIZE_REG_DIR (SIZE_REG_DIR)
  ) u_dump_seq (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_dump_start (i_dump_start),
    .i_dump_ready (i_dump_ready),
    .o_fetch_addr (fetch_addr),
    .i_fetch_data (fetch_data),
    .o_dump_valid (o_dump_valid),
    .o_dump_idx   (o_dump_idx),
    .o_dump_data  (o_dump_data),
    .o_dump_done  (o_dump_done)
  );

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed scenarios plus random
// traffic compared against a behavioural model of the register file and dump.
module tb_register_bank;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_reg_write;
  logic [4:0]  i_wr_addr;
  logic [31:0] i_wr_data;
  logic [4:0]  i_rd_addr_a;
  logic [4:0]  i_rd_addr_b;
  logic [31:0] o_rd_data_a;
  logic [31:0] o_rd_data_b;
  logic        i_dump_start;
  logic        i_dump_ready;
  logic        o_dump_valid;
  logic [4:0]  o_dump_idx;
  logic [31:0] o_dump_data;
  logic        o_dump_done;

  logic [31:0] model_regs [32];
  bit          exp_valid;
  bit          exp_done;
  int          exp_idx;
  logic [31:0] exp_data;

  int total_checks;
  int bad_checks;

  register_bank dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_reg_write  (i_reg_write),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_rd_addr_a  (i_rd_addr_a),
    .i_rd_addr_b  (i_rd_addr_b),
    .o_rd_data_a  (o_rd_data_a),
    .o_rd_data_b  (o_rd_data_b),
    .i_dump_start (i_dump_start),
    .i_dump_ready (i_dump_ready),
    .o_dump_valid (o_dump_valid),
    .o_dump_idx   (o_dump_idx),
    .o_dump_data  (o_dump_data),
    .o_dump_done  (o_dump_done)
  );

  // Free-running 10-unit clock.
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Hard stop in case something stalls the main sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] ra, input bit we,
                                            input logic [4:0] wa, input logic [31:0] wd);
    if (ra == 5'd0) return 32'h0;
    if (we && (wa == ra)) return wd;
    return model_regs[ra];
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    exp_idx   = 0;
    exp_data  = 32'h0;
  endtask

  // One clock cycle: drive at the falling edge, check reads mid-cycle, advance
  // the model at the rising edge and check dump outputs just after it.
  task automatic applyStimulus(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] ra, input logic [4:0] rb,
                               input bit start, input bit ready);
    i_reg_write  = we;
    i_wr_addr    = wa;
    i_wr_data    = wd;
    i_rd_addr_a  = ra;
    i_rd_addr_b  = rb;
    i_dump_start = start;
    i_dump_ready = ready;
    #1;
    checkOutput("rd_a", o_rd_data_a, modelRead(ra, we, wa, wd));
    checkOutput("rd_b", o_rd_data_b, modelRead(rb, we, wa, wd));
    @(posedge i_clk);
    if (we && (wa != 5'd0)) model_regs[wa] = wd;
    if (exp_valid) begin
      if (ready) begin
        if (exp_idx == 31) begin
          exp_valid = 1'b0;
          exp_done  = 1'b1;
        end else begin
          exp_idx++;
          exp_data = model_regs[exp_idx];
        end
      end
    end else if (exp_done) begin
      exp_done = 1'b0;
    end else if (start) begin
      exp_valid = 1'b1;
      exp_idx   = 0;
      exp_data  = 32'h0;
    end
    #1;
    checkOutput("dump_valid", {31'b0, o_dump_valid}, {31'b0, exp_valid});
    checkOutput("dump_done", {31'b0, o_dump_done}, {31'b0, exp_done});
    if (exp_valid) begin
      checkOutput("dump_idx", {27'b0, o_dump_idx}, exp_idx);
      checkOutput("dump_data", o_dump_data, exp_data);
    end
    @(negedge i_clk);
  endtask

  task automatic loadIndexValues();
    for (int r = 1; r < 32; r++) begin
      applyStimulus(1'b1, 5'(r), 32'(r), 5'(r), 5'(r - 1), 1'b0, 1'b0);
    end
  endtask

  initial begin
    int done_count;
    int word_count;
    logic [31:0] idx10_data;
    bit idx10_seen;
    logic [4:0] wa;
    logic [4:0] ra;

    total_checks = 0;
    bad_checks   = 0;
    resetModel();
    i_rst_n      = 1'b0;
    i_reg_write  = 1'b0;
    i_wr_addr    = 5'd0;
    i_wr_data    = 32'h0;
    i_rd_addr_a  = 5'd3;
    i_rd_addr_b  = 5'd31;
    i_dump_start = 1'b0;
    i_dump_ready = 1'b0;

    // Reset state.
    #2;
    checkOutput("rst_valid", {31'b0, o_dump_valid}, 32'h0);
    checkOutput("rst_done", {31'b0, o_dump_done}, 32'h0);
    checkOutput("rst_idx", {27'b0, o_dump_idx}, 32'h0);
    checkOutput("rst_data", o_dump_data, 32'h0);
    checkOutput("rst_rd_a", o_rd_data_a, 32'h0);
    checkOutput("rst_rd_b", o_rd_data_b, 32'h0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Basic write then read, write to r0, same-cycle bypass.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd1, 1'b0, 1'b0);
    checkOutput("r5_readback", o_rd_data_a, 32'hDEADBEEF);
    applyStimulus(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
    checkOutput("r0_read_a", o_rd_data_a, 32'h0);
    checkOutput("r0_read_b", o_rd_data_b, 32'h0);
    i_reg_write = 1'b1;
    i_wr_addr   = 5'd7;
    i_wr_data   = 32'hCAFEF00D;
    i_rd_addr_a = 5'd7;
    i_rd_addr_b = 5'd7;
    #1;
    checkOutput("bypass_a", o_rd_data_a, 32'hCAFEF00D);
    checkOutput("bypass_b", o_rd_data_b, 32'hCAFEF00D);
    applyStimulus(1'b1, 5'd7, 32'hCAFEF00D, 5'd7, 5'd7, 1'b0, 1'b0);

    // Random register traffic, biased towards read-after-write collisions.
    for (int c = 0; c < 150; c++) begin
      wa = 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      applyStimulus(1'($urandom_range(0, 1)), wa, $urandom, ra,
                    5'($urandom_range(0, 31)), 1'b0, 1'b0);
    end

    // Full-speed dump of r[i] = i.
    loadIndexValues();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd2, 1'b1, 1'b1);
    done_count = 0;
    word_count = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_dump_valid) word_count++;
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 1'b0, 1'b1);
      if (o_dump_done) done_count++;
    end
    checkOutput("full_words", word_count, 32'd32);
    checkOutput("full_done_count", done_count, 32'd1);

    // Throttled dump with a write to r10 while index 9 is held.
    loadIndexValues();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0);
    done_count = 0;
    idx10_seen = 1'b0;
    idx10_data = 32'h0;
    for (int c = 0; c < 100; c++) begin
      bit rdy;
      bit hit;
      rdy = c[0];
      hit = exp_valid && (exp_idx == 9) && !rdy;
      applyStimulus(hit, 5'd10, 32'hAAAA5555, 5'd10, 5'd9, 1'b0, rdy);
      if (o_dump_valid && (o_dump_idx == 5'd10) && !idx10_seen) begin
        idx10_seen = 1'b1;
        idx10_data = o_dump_data;
      end
      if (o_dump_done) done_count++;
    end
    checkOutput("idx10_data", idx10_data, 32'hAAAA5555);
    checkOutput("throttle_done_count", done_count, 32'd1);

    // Random dumps with random handshake, writes and stray start requests.
    for (int c = 0; c < 250; c++) begin
      wa = 5'($urandom_range(0, 31));
      applyStimulus(1'($urandom_range(0, 1)), wa, $urandom, wa,
                    5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 1)));
    end
    for (int c = 0; c < 80; c++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b1);
    end

    // Reset in the middle of a dump at index 12.
    loadIndexValues();
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b1);
    for (int c = 0; c < 50; c++) begin
      if (exp_valid && (exp_idx == 12)) break;
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b1);
    end
    checkOutput("reached_idx12", {27'b0, o_dump_idx}, 32'd12);
    i_reg_write = 1'b0;
    i_rst_n     = 1'b0;
    resetModel();
    #1;
    checkOutput("midrst_valid", {31'b0, o_dump_valid}, 32'h0);
    checkOutput("midrst_done", {31'b0, o_dump_done}, 32'h0);
    checkOutput("midrst_idx", {27'b0, o_dump_idx}, 32'h0);
    checkOutput("midrst_data", o_dump_data, 32'h0);
    for (int r = 0; r < 32; r++) begin
      i_rd_addr_a = 5'(r);
      i_rd_addr_b = 5'(31 - r);
      #1;
      checkOutput("midrst_rd_a", o_rd_data_a, 32'h0);
      checkOutput("midrst_rd_b", o_rd_data_b, 32'h0);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    applyStimulus(1'b1, 5'd3, 32'h00000055, 5'd0, 5'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 1'b1);
    checkOutput("first_write_r3", o_rd_data_a, 32'h00000055);
    done_count = 0;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd12, 5'd13, 1'b0, 1'b1);
      if (o_dump_done) done_count++;
    end
    checkOutput("abort_done_count", done_count, 32'd0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL have parameter SIZE, default 32, data word width in bits.
REQ-002 SHALL have parameter SIZE_REG_DIR, default $clog2(SIZE) (5), register address width.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port i_reg_write  input  1  write-back enable.
REQ-006 SHALL have port i_wr_addr  input  SIZE_REG_DIR  write-back destination register.
REQ-007 SHALL have port i_wr_data  input  SIZE  write-back data (selected memory-read or ALU result).
REQ-008 SHALL have port i_rd_addr_a  input  SIZE_REG_DIR  read port A address (rs).
REQ-009 SHALL have port i_rd_addr_b  input  SIZE_REG_DIR  read port B address (rt).
REQ-010 SHALL have port o_rd_data_a  output  SIZE  read port A data.
REQ-011 SHALL have port o_rd_data_b  output  SIZE  read port B data.
REQ-012 SHALL have port i_dump_start  input  1  single-cycle request to stream all registers out.
REQ-013 SHALL have port i_dump_ready  input  1  consumer accepts the current dump word.
REQ-014 SHALL have port o_dump_valid  output  1  dump word presented.
REQ-015 SHALL have port o_dump_idx  output  SIZE_REG_DIR  index of the presented dump word.
REQ-016 SHALL have port o_dump_data  output  SIZE  presented dump word.
REQ-017 SHALL have port o_dump_done  output  1  one-cycle pulse after the last word is accepted.

Function
REQ-018 SHALL hold 2**SIZE_REG_DIR registers of SIZE bits.
REQ-019 SHALL write i_wr_data to register i_wr_addr on the rising edge when i_reg_write=1 and i_wr_addr!=0.
REQ-020 SHALL ignore writes to register 0; register 0 SHALL always read 0.
REQ-021 SHALL drive read ports combinationally (zero-cycle latency) from current contents.
REQ-022 SHALL bypass: when i_reg_write=1, i_wr_addr!=0 and i_wr_addr equals a read address, that port SHALL return i_wr_data in the same cycle.
REQ-023 SHALL both read ports address the same register independently with identical results.
REQ-024 SHALL implement dump FSM states IDLE, DUMP, DONE.
REQ-025 IDLE: on i_dump_start=1 SHALL go to DUMP with index 0 and load o_dump_data with register 0 content (0); o_dump_valid=1 from the next cycle.
REQ-026 DUMP: o_dump_valid=1; o_dump_idx and o_dump_data SHALL remain stable while i_dump_ready=0.
REQ-027 DUMP: on i_dump_ready=1 with index<31, index SHALL increment and o_dump_data SHALL load register[index+1], including bypass of a same-cycle write to that register.
REQ-028 DUMP: on i_dump_ready=1 with index=31, SHALL go to DONE, drop o_dump_valid.
REQ-029 DONE: o_dump_done=1 for exactly one cycle, then IDLE.
REQ-030 SHALL ignore i_dump_start in DUMP and DONE.
REQ-031 Write-back during DUMP SHALL proceed normally; words already captured in o_dump_data SHALL NOT change.

Reset
REQ-032 On i_rst_n=0 all registers SHALL clear to 0, FSM SHALL enter IDLE, index 0, o_dump_valid=0, o_dump_done=0, o_dump_data=0, o_dump_idx=0.
REQ-033 Reset asserted mid-dump SHALL abort the dump with no o_dump_done pulse.
REQ-034 First write SHALL take effect on the first rising edge after i_rst_n deasserts.

Structure
REQ-035 SIZE, SIZE_REG_DIR, register count and FSM state encodings SHALL live in the shared MIPS constants package/include.
REQ-036 Dump FSM and index counter SHALL be a sub-module named regbank_dump_seq; storage, write and read/bypass logic stay in register_bank.

Verification
REQ-037 Reset, then write 0xDEADBEEF to r5, read A=r5 next cycle -> o_rd_data_a=0xDEADBEEF.
REQ-038 Write 0x12345678 to r0, read A=B=r0 -> both 0x00000000.
REQ-039 Same-cycle write 0xCAFEF00D to r7 with read A=r7, B=r7 -> both 0xCAFEF00D that cycle.
REQ-040 r1..r31 loaded with value=index, i_dump_start, i_dump_ready=1 -> 32 words idx 0..31 data 0..31 on consecutive cycles, then single o_dump_done.
REQ-041 Dump with i_dump_ready toggling 1/0 and write 0xAAAA5555 to r10 while idx=9 is held -> idx 9 data stable, idx 10 delivers 0xAAAA5555.
REQ-042 i_rst_n=0 while idx=12 -> o_dump_valid=0 immediately, all registers read 0, no o_dump_done.
